// File: rtl/fp16_pkg.sv
// Shared constants and state encoding for the FP16 normalise/round stage.
package fp16_pkg;

  localparam int EMIN        = -14;
  localparam int EMAX        = 15;
  localparam int FP16_MANT_W = 11;
  localparam int FP16_EXP_W  = 7;
  localparam int WORK_EXP_W  = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_NORM  = ST_NORM,
    S_ROUND = ST_ROUND,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even on an 11-bit kept mantissa; carry flags overflow to 2.0.
module fp16_round_rne
  import fp16_pkg::*;
(
  input  logic [FP16_MANT_W-1:0] keep,
  input  logic                   guard,
  input  logic                   sticky,
  output logic [FP16_MANT_W-1:0] mant,
  output logic                   carry
);

  logic                 round_up;
  logic [FP16_MANT_W:0] sum;

  always_comb begin
    round_up = guard & (sticky | keep[0]);
    sum      = {1'b0, keep} + {{FP16_MANT_W{1'b0}}, round_up};
    carry    = sum[FP16_MANT_W];
    // 2.0 renormalises to 1.0 with the exponent bumped by the caller
    mant     = carry ? {1'b1, {(FP16_MANT_W-1){1'b0}}} : sum[FP16_MANT_W-1:0];
  end

endmodule

// File: rtl/fp16_normalize_iter.sv
// Iterative normaliser: one shift per cycle into 1.xxx or subnormal form, then RNE rounding.
// Handshake: an operand transfers on a rising edge where in_valid & in_ready; it_valid pulses for one enabled cycle.
module fp16_normalize_iter
  import fp16_pkg::*;
#(
  parameter int MANT_IN_W = 22,
  parameter int EXP_IN_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_in,
  input  logic [EXP_IN_W-1:0]    exp_in,
  input  logic [MANT_IN_W-1:0]   mant_in,
  input  logic                   is_nan_in,
  input  logic                   is_pinf_in,
  input  logic                   is_ninf_in,
  input  logic                   result_in,
  output logic                   it_valid,
  output logic                   sign_out,
  output logic [FP16_EXP_W-1:0]  exp_out,
  output logic [FP16_MANT_W-1:0] mant_out,
  output logic                   is_nan_out,
  output logic                   is_pinf_out,
  output logic                   is_ninf_out,
  output logic                   result_out,
  output state_t                 state_dbg
);

  localparam int TOP  = MANT_IN_W - 1;
  localparam int LEAD = MANT_IN_W - 2;
  localparam int GRD  = LEAD - FP16_MANT_W;
  localparam logic signed [WORK_EXP_W-1:0] EMIN_X  = WORK_EXP_W'(EMIN);
  localparam logic signed [WORK_EXP_W-1:0] EMAX_X  = WORK_EXP_W'(EMAX);
  localparam logic signed [WORK_EXP_W-1:0] FLUSH_X = WORK_EXP_W'(EMIN - FP16_MANT_W - 2);
  localparam logic signed [WORK_EXP_W-1:0] ONE_X   = WORK_EXP_W'(1);
  localparam logic [FP16_EXP_W-1:0]        EXP_ZERO = FP16_EXP_W'(EMIN);

  state_t state, state_d;

  logic                         w_sign, w_sign_d;
  logic signed [WORK_EXP_W-1:0] w_exp, w_exp_d;
  logic [MANT_IN_W-1:0]         w_mant, w_mant_d;
  logic                         w_sticky, w_sticky_d;
  logic                         w_result, w_result_d;

  logic                   o_sign_d, o_nan_d, o_pinf_d, o_ninf_d, o_result_d;
  logic [FP16_EXP_W-1:0]  o_exp_d;
  logic [FP16_MANT_W-1:0] o_mant_d;

  logic signed [WORK_EXP_W-1:0] exp_in_ext;
  logic signed [WORK_EXP_W-1:0] exp_r;
  logic [FP16_MANT_W-1:0]       rnd_mant;
  logic                         rnd_carry;
  logic                         rnd_sticky;

  assign exp_in_ext = WORK_EXP_W'($signed(exp_in));
  assign rnd_sticky = (|w_mant[GRD-1:0]) | w_sticky;
  assign exp_r      = w_exp + $signed({{(WORK_EXP_W-1){1'b0}}, rnd_carry});

  fp16_round_rne u_round (
    .keep   (w_mant[LEAD -: FP16_MANT_W]),
    .guard  (w_mant[GRD]),
    .sticky (rnd_sticky),
    .mant   (rnd_mant),
    .carry  (rnd_carry)
  );

  assign in_ready  = enable && !rst && (state == S_IDLE);
  assign it_valid  = enable && (state == S_DONE);
  assign state_dbg = state;

  always_comb begin
    state_d    = state;
    w_sign_d   = w_sign;
    w_exp_d    = w_exp;
    w_mant_d   = w_mant;
    w_sticky_d = w_sticky;
    w_result_d = w_result;
    o_sign_d   = sign_out;
    o_exp_d    = exp_out;
    o_mant_d   = mant_out;
    o_nan_d    = is_nan_out;
    o_pinf_d   = is_pinf_out;
    o_ninf_d   = is_ninf_out;
    o_result_d = result_out;

    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_d   = sign_in;
          w_exp_d    = exp_in_ext;
          w_mant_d   = mant_in;
          w_sticky_d = 1'b0;
          w_result_d = result_in;
          if (is_nan_in || is_pinf_in || is_ninf_in) begin
            state_d    = S_DONE;
            o_sign_d   = sign_in;
            o_exp_d    = '0;
            o_mant_d   = '0;
            o_nan_d    = is_nan_in;
            o_pinf_d   = is_pinf_in;
            o_ninf_d   = is_ninf_in;
            o_result_d = result_in;
          end else if (mant_in == '0 || exp_in_ext < FLUSH_X) begin
            // too small to survive rounding: emit signed zero straight away
            state_d    = S_DONE;
            o_sign_d   = sign_in;
            o_exp_d    = EXP_ZERO;
            o_mant_d   = '0;
            o_nan_d    = 1'b0;
            o_pinf_d   = 1'b0;
            o_ninf_d   = 1'b0;
            o_result_d = result_in;
          end else begin
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (w_mant[TOP] || w_exp < EMIN_X) begin
          w_mant_d   = w_mant >> 1;
          w_exp_d    = w_exp + ONE_X;
          w_sticky_d = w_sticky | w_mant[0];
        end else if (!w_mant[LEAD] && w_exp > EMIN_X) begin
          w_mant_d = w_mant << 1;
          w_exp_d  = w_exp - ONE_X;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d    = S_DONE;
        o_sign_d   = w_sign;
        o_nan_d    = 1'b0;
        o_result_d = w_result;
        if (exp_r > EMAX_X) begin
          o_exp_d  = '0;
          o_mant_d = '0;
          o_pinf_d = !w_sign;
          o_ninf_d = w_sign;
        end else begin
          o_exp_d  = exp_r[FP16_EXP_W-1:0];
          o_mant_d = rnd_mant;
          o_pinf_d = 1'b0;
          o_ninf_d = 1'b0;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      w_sign      <= 1'b0;
      w_exp       <= '0;
      w_mant      <= '0;
      w_sticky    <= 1'b0;
      w_result    <= 1'b0;
      sign_out    <= 1'b0;
      exp_out     <= '0;
      mant_out    <= '0;
      is_nan_out  <= 1'b0;
      is_pinf_out <= 1'b0;
      is_ninf_out <= 1'b0;
      result_out  <= 1'b0;
    end else if (enable) begin
      state       <= state_d;
      w_sign      <= w_sign_d;
      w_exp       <= w_exp_d;
      w_mant      <= w_mant_d;
      w_sticky    <= w_sticky_d;
      w_result    <= w_result_d;
      sign_out    <= o_sign_d;
      exp_out     <= o_exp_d;
      mant_out    <= o_mant_d;
      is_nan_out  <= o_nan_d;
      is_pinf_out <= o_pinf_d;
      is_ninf_out <= o_ninf_d;
      result_out  <= o_result_d;
    end
  end

endmodule

// File: tb/tb_fp16_normalize_iter.sv
// Directed bench for fp16_normalize_iter with hand-computed expected results and latencies.
module tb_fp16_normalize_iter;
  import fp16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [21:0] mant_in = '0;
  logic        is_nan_in = 1'b0, is_pinf_in = 1'b0, is_ninf_in = 1'b0;
  logic        result_in = 1'b0;
  logic        it_valid, sign_out, is_nan_out, is_pinf_out, is_ninf_out, result_out;
  logic [6:0]  exp_out;
  logic [10:0] mant_out;
  state_t      state_dbg;

  int checks = 0;
  int failures = 0;

  fp16_normalize_iter #(.MANT_IN_W(22), .EXP_IN_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .is_nan_in(is_nan_in), .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in),
    .result_in(result_in), .it_valid(it_valid), .sign_out(sign_out), .exp_out(exp_out),
    .mant_out(mant_out), .is_nan_out(is_nan_out), .is_pinf_out(is_pinf_out),
    .is_ninf_out(is_ninf_out), .result_out(result_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one operand; lat counts rising edges from the transfer edge to the one entering DONE.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [21:0] m,
                        input logic [2:0] fl, input logic r, output int lat);
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    sign_in = s; exp_in = e; mant_in = m; result_in = r;
    {is_nan_in, is_pinf_in, is_ninf_in} = fl;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    {is_nan_in, is_pinf_in, is_ninf_in} = 3'b000;
    while (!it_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic s, input logic [7:0] e,
                          input logic [21:0] m, input logic [2:0] fl, input logic r,
                          input int exp_lat, input logic [10:0] exp_mant,
                          input logic [6:0] exp_e, input logic [2:0] exp_fl);
    int lat;
    run_op(s, e, m, fl, r, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_mant"}, {21'b0, mant_out}, {21'b0, exp_mant});
    check({tag, "_exp"}, {25'b0, exp_out}, {25'b0, exp_e});
    check({tag, "_sign"}, {31'b0, sign_out}, {31'b0, s});
    check({tag, "_flags"}, {29'b0, is_nan_out, is_pinf_out, is_ninf_out}, {29'b0, exp_fl});
    check({tag, "_result"}, {31'b0, result_out}, {31'b0, r});
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'b0, it_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    // reset state
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_outputs", {12'b0, it_valid, sign_out, exp_out, mant_out, is_nan_out, is_pinf_out,
                          is_ninf_out, result_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // exact 1.0, no shifts
    op_check("one", 1'b0, 8'h00, 22'h100000, 3'b000, 1'b1, 3, 11'h400, 7'h00, 3'b000);
    // 14 left shifts down to subnormal
    op_check("subn", 1'b0, 8'h00, 22'h000001, 3'b000, 1'b0, 17, 11'h010, 7'h72, 3'b000);
    // round carry to 2.0
    op_check("carry", 1'b1, 8'h00, 22'h1FFFFF, 3'b000, 1'b0, 3, 11'h400, 7'h01, 3'b000);
    // ties to even
    op_check("tie_even", 1'b0, 8'h00, 22'h100200, 3'b000, 1'b0, 3, 11'h400, 7'h00, 3'b000);
    op_check("tie_odd", 1'b0, 8'h00, 22'h100600, 3'b000, 1'b1, 3, 11'h402, 7'h00, 3'b000);
    // overflow after right shift, negative
    op_check("ninf", 1'b1, 8'h0F, 22'h200000, 3'b000, 1'b0, 4, 11'h000, 7'h00, 3'b001);
    // overflow via round carry, positive
    op_check("pinf", 1'b0, 8'h0F, 22'h1FFFFF, 3'b000, 1'b0, 3, 11'h000, 7'h00, 3'b010);
    // special value pass-through
    op_check("nan", 1'b0, 8'h00, 22'h123456, 3'b100, 1'b1, 1, 11'h000, 7'h00, 3'b100);
    // zero and flush-to-zero
    op_check("zero", 1'b1, 8'h05, 22'h000000, 3'b000, 1'b0, 1, 11'h000, 7'h72, 3'b000);
    op_check("flush", 1'b0, 8'hE4, 22'h100000, 3'b000, 1'b1, 1, 11'h000, 7'h72, 3'b000);
    // subnormal 0x3FF rounds up to smallest normal
    op_check("subn_up", 1'b0, 8'hF2, 22'h0FFE00, 3'b000, 1'b0, 3, 11'h400, 7'h72, 3'b000);
    // right shift feeds sticky, turning a tie into round-up
    op_check("sticky", 1'b0, 8'hF1, 22'h100401, 3'b000, 1'b0, 4, 11'h201, 7'h72, 3'b000);

    // 5-cycle stall mid-NORM
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'h00; mant_in = 22'h000001; result_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!it_valid && lat < 60) begin
      if (lat == 3) enable = 1'b0;
      if (lat == 8) enable = 1'b1;
      if (lat == 4) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check("stall_lat", lat, 32'd22);
    check("stall_mant", {21'b0, mant_out}, {21'b0, 11'h010});
    check("stall_exp", {25'b0, exp_out}, {25'b0, 7'h72});
    @(negedge clk);

    // reset mid-NORM abandons the operand
    @(negedge clk);
    sign_in = 1'b1; exp_in = 8'h00; mant_in = 22'h000001; result_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {12'b0, it_valid, sign_out, exp_out, mant_out, is_nan_out,
                             is_pinf_out, is_ninf_out, result_out}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (it_valid) seen++;
    end
    check("midrst_no_valid", seen, 32'd0);
    check("midrst_ready_after", {31'b0, in_ready}, 32'd1);

    // stage still works after the abandoned operand
    op_check("after_rst", 1'b0, 8'h00, 22'h100600, 3'b000, 1'b0, 3, 11'h402, 7'h00, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
